dec_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 4-input/2-output decoder datapath between four requesters.
- Grants the resource to one requester at a time and holds the grant while that request stays asserted.
- Forces release after a programmable hold limit and inserts one dead cycle between owners so the shared decoder inputs settle.
- Drives a one-hot grant plus a 2-bit binary owner index used as the decoder input-mux select.

---
 rtl/dec_sched_pkg.sv | 29 ++
 rtl/rr_pick4.sv | 27 ++
 rtl/dec_rr_sched.sv | 111 +++++++++++
 tb/tb_dec_rr_sched.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dec_sched_pkg.sv
// rtl/dec_sched_pkg.sv - shared types and helpers for the round-robin decoder scheduler
package dec_sched_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] encode(input logic [N_REQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - rotate-priority picker: first requester at or after ptr, wrapping mod 4
module rr_pick4
    import dec_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_vld
);

    logic [IDX_W-1:0] w_idx;

    // Scan farthest-from-ptr first so the nearest requester wins the last write.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        w_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = ptr + IDX_W'(k);
            if (req[w_idx]) begin
                pick_idx = w_idx;
                pick_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dec_rr_sched.sv
// rtl/dec_rr_sched.sv - round-robin owner scheduler for the shared 4-in/2-out decoder
module dec_rr_sched
    import dec_sched_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             expire
);

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    sched_state_t     r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_vld, w_vld_nxt;
    logic             r_expire, w_expire_nxt;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_vld;
    logic             w_hold_hit;

    rr_pick4 u_pick (
        .req      (req),
        .ptr      (r_ptr),
        .pick_idx (w_pick_idx),
        .pick_vld (w_pick_vld)
    );

    assign w_hold_hit = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_gnt_nxt    = r_gnt;
        w_idx_nxt    = r_idx;
        w_vld_nxt    = r_vld;
        w_expire_nxt = 1'b0;
        case (r_state)
            IDLE, GAP: begin
                if (w_pick_vld) begin
                    w_gnt_nxt   = onehot(w_pick_idx);
                    w_idx_nxt   = w_pick_idx;
                    w_vld_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = GRANT;
                end else begin
                    w_gnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            GRANT: begin
                // An owner dropping on the limit edge is a normal release, so expire
                // only fires when the owner is still requesting.
                if (!req[r_idx] || w_hold_hit) begin
                    w_gnt_nxt    = '0;
                    w_idx_nxt    = '0;
                    w_vld_nxt    = 1'b0;
                    w_ptr_nxt    = r_idx + 2'd1;
                    w_expire_nxt = req[r_idx];
                    w_state_nxt  = GAP;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_vld_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_idx    <= '0;
            r_vld    <= 1'b0;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_idx    <= w_idx_nxt;
            r_vld    <= w_vld_nxt;
            r_expire <= w_expire_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_idx;
    assign gnt_vld = r_vld;
    assign expire  = r_expire;

endmodule

// File: tb/tb_dec_rr_sched.sv
// tb/tb_dec_rr_sched.sv - directed self-checking bench for dec_rr_sched
module tb_dec_rr_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;

    logic [3:0] g15, g3, g4, g0;
    logic [1:0] i15, i3, i4, i0;
    logic       v15, v3, v4, v0;
    logic       e15, e3, e4, e0;

    int n_tests = 0;
    int n_fail  = 0;

    dec_rr_sched #(.MAX_HOLD(15), .CNT_W(4)) u15 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(g15), .gnt_idx(i15), .gnt_vld(v15), .expire(e15)
    );
    dec_rr_sched #(.MAX_HOLD(3), .CNT_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(g3), .gnt_idx(i3), .gnt_vld(v3), .expire(e3)
    );
    dec_rr_sched #(.MAX_HOLD(4), .CNT_W(2)) u4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(g4), .gnt_idx(i4), .gnt_vld(v4), .expire(e4)
    );
    dec_rr_sched #(.MAX_HOLD(0), .CNT_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(g0), .gnt_idx(i0), .gnt_vld(v0), .expire(e0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        rst_n = 1'b0;
        req   = 4'b0000;

        cyc();
        chk("rst_gnt", 32'(g15), 32'h0);
        chk("rst_idx", 32'(i15), 32'h0);
        chk("rst_vld", 32'(v15), 32'h0);
        chk("rst_exp", 32'(e15), 32'h0);
        rst_n = 1'b1;

        // Single requester 2 held for five sampling edges
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("single_gnt", 32'(g15), 32'h4);
            chk("single_idx", 32'(i15), 32'h2);
            chk("single_vld", 32'(v15), 32'h1);
        end
        req = 4'b0000;
        cyc();
        chk("single_gap_gnt", 32'(g15), 32'h0);
        chk("single_gap_exp", 32'(e15), 32'h0);
        cyc();
        chk("single_idle_gnt", 32'(g15), 32'h0);
        chk("single_idle_vld", 32'(v15), 32'h0);

        // Rotation with MAX_HOLD=3
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            for (int j = 0; j < 3; j++) begin
                cyc();
                chk("rot_gnt", 32'(g3), 32'(exp_g));
                chk("rot_idx", 32'(i3), 32'(k % 4));
                chk("rot_exp_low", 32'(e3), 32'h0);
            end
            cyc();
            chk("rot_gap_gnt", 32'(g3), 32'h0);
            chk("rot_gap_exp", 32'(e3), 32'h1);
        end

        // Fairness after a normal release
        do_reset();
        req = 4'b0010;
        cyc();
        chk("fair_own1", 32'(g15), 32'h2);
        req = 4'b1011;
        cyc();
        chk("fair_no_preempt", 32'(g15), 32'h2);
        req = 4'b1001;
        cyc();
        chk("fair_gap", 32'(g15), 32'h0);
        chk("fair_gap_exp", 32'(e15), 32'h0);
        cyc();
        chk("fair_next3_gnt", 32'(g15), 32'h8);
        chk("fair_next3_idx", 32'(i15), 32'h3);
        req = 4'b0011;
        cyc();
        chk("fair_gap2", 32'(g15), 32'h0);
        cyc();
        chk("fair_next0_gnt", 32'(g15), 32'h1);
        chk("fair_next0_idx", 32'(i15), 32'h0);

        // Owner drop coincides with the hold limit (MAX_HOLD=4)
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("sim_gnt", 32'(g4), 32'h1);
            chk("sim_exp_low", 32'(e4), 32'h0);
        end
        req = 4'b0000;
        cyc();
        chk("sim_gap_gnt", 32'(g4), 32'h0);
        chk("sim_gap_exp", 32'(e4), 32'h0);
        req = 4'b0011;
        cyc();
        chk("sim_ptr1_gnt", 32'(g4), 32'h2);
        chk("sim_ptr1_idx", 32'(i4), 32'h1);

        // Unlimited hold (MAX_HOLD=0)
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk("nolim_gnt", 32'(g0), 32'h8);
            chk("nolim_exp", 32'(e0), 32'h0);
        end

        // Asynchronous reset while requester 1 owns, after ptr has moved to 3
        do_reset();
        req = 4'b0100;
        cyc();
        chk("ar_own2", 32'(g15), 32'h4);
        req = 4'b0010;
        cyc();
        chk("ar_gap", 32'(g15), 32'h0);
        cyc();
        chk("ar_own1", 32'(g15), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_async_gnt", 32'(g15), 32'h0);
        chk("ar_async_idx", 32'(i15), 32'h0);
        chk("ar_async_vld", 32'(v15), 32'h0);
        chk("ar_async_exp", 32'(e15), 32'h0);
        req = 4'b1010;
        cyc();
        chk("ar_held_gnt", 32'(g15), 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("ar_first_gnt", 32'(g15), 32'h2);
        chk("ar_first_idx", 32'(i15), 32'h1);
        chk("ar_first_vld", 32'(v15), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
